lif_array: RTL and testbench

Time-multiplexed array of leaky integrate-and-fire neurons sharing one integrate/compare datapath. It is the parametrised successor of the single 8-bit LIF neuron, adding neuron count, membrane width, run-time threshold and leak, saturating arithmetic, an optional refractory period and valid/ready handshakes on both sides. One accepted input vector is one network timestep. The array sits between the input current encoder and the spike router.

---
 rtl/lif_array_if.sv | 25 ++
 rtl/lif_array.sv | 79 +++++++
 tb/tb_lif_array.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/lif_array_if.sv
// lif_array_if: timestep handshake, per-neuron currents, run-time config and spike/state results.
interface lif_array_if #(
  parameter int WIDTH    = 8,
  parameter int NEURONS  = 4,
  parameter int REFRAC_W = 3
);
  logic                     in_valid;
  logic                     in_ready;
  logic [NEURONS*WIDTH-1:0] in_current;
  logic [WIDTH-1:0]         threshold;
  logic [1:0]               decay_shift;
  logic [REFRAC_W-1:0]      refrac;
  logic                     out_valid;
  logic                     out_ready;
  logic [NEURONS-1:0]       spikes;
  logic [NEURONS*WIDTH-1:0] out_state;
  modport master (
    output in_valid, in_current, threshold, decay_shift, refrac, out_ready,
    input  in_ready, out_valid, spikes, out_state
  );
  modport slave (
    input  in_valid, in_current, threshold, decay_shift, refrac, out_ready,
    output in_ready, out_valid, spikes, out_state
  );
endinterface

// File: rtl/lif_array.sv
// lif_array: time-multiplexed leaky integrate-and-fire array, one shared update datapath.
// Refractory counters exist only when LIF_REFRAC_EN is defined.
module lif_array #(
  parameter int WIDTH    = 8,
  parameter int NEURONS  = 4,
  parameter int REFRAC_W = 3
) (
  input logic        clk,
  input logic        rst,
  lif_array_if.slave bus
);
  localparam int IW = $clog2(NEURONS);
  localparam logic [1:0] S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2;
  logic [1:0]               r_state;
  logic [IW-1:0]            r_idx;
  logic [NEURONS*WIDTH-1:0] r_cur, r_mem;
  logic [WIDTH-1:0]         r_thr;
  logic [1:0]               r_k;
  logic [NEURONS-1:0]       r_spk;
  logic [WIDTH-1:0]         w_s, w_c, w_vs;
  logic [WIDTH:0]           w_v;
  logic                     w_fire, w_busy, w_last;
  assign w_s    = r_mem[r_idx*WIDTH +: WIDTH];
  assign w_c    = r_cur[r_idx*WIDTH +: WIDTH];
  // state - (state >> k) never underflows, so one extra bit covers the sum
  assign w_v    = {1'b0, w_s} + {1'b0, w_c} - {1'b0, w_s >> r_k};
  assign w_vs   = w_v[WIDTH] ? '1 : w_v[WIDTH-1:0];
  assign w_fire = w_vs >= r_thr;
  assign w_last = r_idx == IW'(NEURONS - 1);
  assign bus.in_ready  = r_state == S_IDLE;
  assign bus.out_valid = r_state == S_DONE;
  assign bus.spikes    = r_spk;
  assign bus.out_state = r_mem;
`ifdef LIF_REFRAC_EN
  logic [NEURONS*REFRAC_W-1:0] r_rc;
  logic [REFRAC_W-1:0]         r_ref, w_rc;
  assign w_rc   = r_rc[r_idx*REFRAC_W +: REFRAC_W];
  assign w_busy = |w_rc;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rc  <= '0;
      r_ref <= '0;
    end else begin
      if (r_state == S_IDLE && bus.in_valid) r_ref <= bus.refrac;
      if (r_state == S_RUN) r_rc[r_idx*REFRAC_W +: REFRAC_W] <= w_busy ? w_rc - REFRAC_W'(1) : w_fire ? r_ref : w_rc;
    end
  end
`else
  logic w_unused;
  assign w_unused = ^bus.refrac;
  assign w_busy   = 1'b0;
`endif
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_cur   <= '0;
      r_mem   <= '0;
      r_thr   <= '0;
      r_k     <= '0;
      r_spk   <= '0;
    end else begin
      if (r_state == S_IDLE && bus.in_valid) begin
        r_cur   <= bus.in_current;
        r_thr   <= bus.threshold;
        r_k     <= bus.decay_shift;
        r_idx   <= '0;
        r_state <= S_RUN;
      end
      if (r_state == S_RUN) begin
        r_mem[r_idx*WIDTH +: WIDTH] <= (w_busy || w_fire) ? '0 : w_vs;
        r_spk[r_idx]                <= !w_busy && w_fire;
        r_idx                       <= r_idx + IW'(1);
        r_state                     <= w_last ? S_DONE : S_RUN;
      end
      if (r_state == S_DONE && bus.out_ready) r_state <= S_IDLE;
    end
  end
endmodule

// File: tb/tb_lif_array.sv
// tb_lif_array: directed and random timesteps against a plain-integer neuron model.
module tb_lif_array;
  localparam int W = 8, N = 4, R = 3;
`ifdef LIF_REFRAC_EN
  localparam bit REN = 1'b1;
`else
  localparam bit REN = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  lif_array_if #(.WIDTH(W), .NEURONS(N), .REFRAC_W(R)) bus();
  lif_array #(.WIDTH(W), .NEURONS(N), .REFRAC_W(R)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
  int checks = 0;
  int errors = 0;
  int m_mem[N];
  int m_rc[N];
  logic [N-1:0]   e_spk;
  logic [N*W-1:0] e_state;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask
  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_mem[i] = 0;
      m_rc[i]  = 0;
    end
  endtask
  task automatic model(input logic [N*W-1:0] cur, input int thr, input int k, input int rf);
    int c, v;
    for (int i = 0; i < N; i++) begin
      c = int'(cur[i*W +: W]);
      if (m_rc[i] > 0) begin
        m_rc[i]--;
        m_mem[i] = 0;
        e_spk[i] = 1'b0;
      end else begin
        v = m_mem[i] + c - (m_mem[i] >> k);
        if (v > (1 << W) - 1) v = (1 << W) - 1;
        if (v >= thr) begin
          e_spk[i] = 1'b1;
          m_mem[i] = 0;
          m_rc[i]  = REN ? rf : 0;
        end else begin
          e_spk[i] = 1'b0;
          m_mem[i] = v;
        end
      end
      e_state[i*W +: W] = W'(m_mem[i]);
    end
  endtask
  task automatic step(input logic [N*W-1:0] cur, input int thr, input int k, input int rf, input int hold);
    logic [N-1:0]   s_spk;
    logic [N*W-1:0] s_state;
    @(negedge clk);
    bus.in_current  = cur;
    bus.threshold   = W'(thr);
    bus.decay_shift = 2'(k);
    bus.refrac      = R'(rf);
    bus.in_valid    = 1'b1;
    chk("in_ready_idle", bus.in_ready, 1);
    @(posedge clk);
    #1;
    bus.in_valid    = 1'b0;
    bus.in_current  = $urandom;
    bus.threshold   = W'($urandom);
    bus.decay_shift = 2'($urandom);
    bus.refrac      = R'($urandom);
    chk("in_ready_run", bus.in_ready, 0);
    model(cur, thr, k, rf);
    repeat (N - 1) @(posedge clk);
    @(negedge clk);
    chk("out_valid_early", bus.out_valid, 0);
    @(negedge clk);
    chk("out_valid_rise", bus.out_valid, 1);
    chk("spikes", bus.spikes, e_spk);
    chk("out_state", bus.out_state, e_state);
    s_spk   = bus.spikes;
    s_state = bus.out_state;
    for (int j = 0; j < hold; j++) begin
      bus.in_valid = (j % 2) == 0;
      @(negedge clk);
      chk("hold_spikes", bus.spikes, s_spk);
      chk("hold_state", bus.out_state, s_state);
      chk("hold_in_ready", bus.in_ready, 0);
      chk("hold_out_valid", bus.out_valid, 1);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    chk("release_out_valid", bus.out_valid, 0);
    chk("release_in_ready", bus.in_ready, 1);
  endtask
  initial begin
    int integ[4];
    int pat[4];
    logic [N*W-1:0] c200;
    integ = '{100, 175, 232, 0};
    pat   = '{1, 0, 0, 1};
    c200  = {N{8'd200}};
    bus.in_valid    = 1'b0;
    bus.out_ready   = 1'b0;
    bus.in_current  = '0;
    bus.threshold   = '0;
    bus.decay_shift = '0;
    bus.refrac      = '0;
    model_reset();
    #1;
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_spikes", bus.spikes, 0);
    chk("rst_state", bus.out_state, 0);
    @(negedge clk);
    rst = 1'b0;
    step(c200, 240, 2, 0, 0);
    @(negedge clk);
    bus.in_current = c200;
    bus.threshold  = 8'd240;
    bus.in_valid   = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    model_reset();
    chk("midrun_out_valid", bus.out_valid, 0);
    chk("midrun_spikes", bus.spikes, 0);
    chk("midrun_state", bus.out_state, 0);
    chk("midrun_in_ready", bus.in_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    for (int s = 0; s < 4; s++) begin
      step({{(N-1)*W{1'b0}}, 8'd100}, 240, 2, 0, (s == 1) ? 10 : 0);
      chk("integ_state0", bus.out_state[W-1:0], integ[s]);
      chk("integ_spike0", bus.spikes[0], s == 3);
    end
    for (int s = 0; s < 4; s++) begin
      step({{(N-2)*W{1'b0}}, 8'd250, 8'd0}, 240, 2, 2, 0);
      chk("refrac_spike1", bus.spikes[1], REN ? pat[s] : 1);
      chk("refrac_state1", bus.out_state[2*W-1:W], 0);
    end
    step(N*W'($urandom), 0, 1, 1, 1);
    for (int s = 0; s < 20; s++)
      step(N*W'({$urandom, $urandom}), int'($urandom_range(0, 255)), int'($urandom_range(0, 3)),
           int'($urandom_range(0, 7)), int'($urandom_range(0, 2)));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
